div_scheduler: RTL

DIV_SCHEDULER -- requirements
Module: div_scheduler

---
 rtl/div_sched_pkg.sv | 23 ++
 rtl/div_result_fifo.sv | 57 +++++
 rtl/div_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/div_sched_pkg.sv
// Shared types for div_scheduler: shadow-pipe entries and result-buffer entries.
// Result fields are sized for the widest supported divider (32-bit dividend and divisor).
package div_sched_pkg;

    localparam int MAX_DIVIDENDLEN = 32;
    localparam int MAX_DIVISORLEN  = 32;

    typedef struct packed {
        logic valid;
        logic id;
        logic divzero;
    } shadow_entry_t;

    typedef struct packed {
        logic                       id;
        logic [MAX_DIVIDENDLEN-1:0] quotient;
        logic [MAX_DIVISORLEN-1:0]  remainder;
        logic                       divzero;
    } result_entry_t;

    localparam int RESULT_W = $bits(result_entry_t);

endpackage

// File: rtl/div_result_fifo.sv
// First-word-fall-through result buffer for div_scheduler.
// DEPTH must be a power of two, >= 2; writes when full and reads when empty are ignored.
module div_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    // The extra pointer bit tells a full buffer apart from an empty one.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr    = i_wr_en & ~w_full;
    assign w_rd    = i_rd_en & ~o_empty;

    // NOTE: storage is deliberately not reset; an empty buffer never exposes it, and the pointers alone define state.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/div_scheduler.sv
// Two-requester round-robin front end for a fixed-latency pipelined divider, with credit-based result buffering.
// Optional feature macro DIV_SCHED_DIVZERO_EN adds rsp_divzero and divide-by-zero result substitution.
module div_scheduler
    import div_sched_pkg::*;
#(
    parameter int DIVIDENDLEN = 16,
    parameter int DIVISORLEN  = 8,
    parameter int LATENCY     = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [DIVIDENDLEN-1:0] req0_dividend,
    input  logic [DIVISORLEN-1:0]  req0_divisor,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [DIVIDENDLEN-1:0] req1_dividend,
    input  logic [DIVISORLEN-1:0]  req1_divisor,
    output logic [DIVIDENDLEN-1:0] div_dividend,
    output logic [DIVISORLEN-1:0]  div_divisor,
    input  logic [DIVIDENDLEN-1:0] div_quotient,
    input  logic [DIVISORLEN-1:0]  div_remainder,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [DIVIDENDLEN-1:0] rsp_quotient,
    output logic [DIVISORLEN-1:0]  rsp_remainder,
`ifdef DIV_SCHED_DIVZERO_EN
    output logic                   rsp_divzero,
`endif
    output logic                   busy
);

    localparam int                  CREDIT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(FIFO_DEPTH);
    localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);

    logic                   r_active;
    logic                   r_ptr;
    logic [CREDIT_W-1:0]    r_credits;
    shadow_entry_t          r_shadow [LATENCY];

    logic                   w_grant_id;
    logic                   w_issue;
    logic                   w_pop;
    logic                   w_fifo_empty;
    logic [DIVIDENDLEN-1:0] w_issue_dividend;
    logic [DIVISORLEN-1:0]  w_issue_divisor;
    shadow_entry_t          w_shadow_in;
    shadow_entry_t          w_shadow_out;
    result_entry_t          w_wr_entry;
    result_entry_t          w_rd_entry;
    logic                   w_unused_rd;

    // A lone valid requester wins outright; the pointer only breaks ties.
    assign w_grant_id = (req0_valid & req1_valid) ? r_ptr : req1_valid;
    assign w_issue    = (req0_valid | req1_valid) & r_active & (r_credits != '0);
    assign req0_ready = w_issue & ~w_grant_id;
    assign req1_ready = w_issue &  w_grant_id;

    assign w_issue_dividend = w_grant_id ? req1_dividend : req0_dividend;
    assign w_issue_divisor  = w_grant_id ? req1_divisor  : req0_divisor;
    assign div_dividend     = w_issue ? w_issue_dividend : '0;
    assign div_divisor      = w_issue ? w_issue_divisor  : '0;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        w_shadow_in       = '0;
        w_shadow_in.valid = w_issue;
        w_shadow_in.id    = w_grant_id;
`ifdef DIV_SCHED_DIVZERO_EN
        w_shadow_in.divzero = (w_issue_divisor == '0);
`else
        w_shadow_in.divzero = 1'b0;
`endif
    end

    // The shadow pipe tracks the divider stage-for-stage and never stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_shadow[0] <= w_shadow_in;
            for (int i = 1; i < LATENCY; i++) begin
                r_shadow[i] <= r_shadow[i-1];
            end
        end
    end

    assign w_shadow_out = r_shadow[LATENCY-1];

    always_comb begin
        w_wr_entry    = '0;
        w_wr_entry.id = w_shadow_out.id;
`ifdef DIV_SCHED_DIVZERO_EN
        if (w_shadow_out.divzero) begin
            w_wr_entry.quotient[DIVIDENDLEN-1:0] = '1;
            w_wr_entry.divzero                   = 1'b1;
        end else begin
            w_wr_entry.quotient[DIVIDENDLEN-1:0] = div_quotient;
            w_wr_entry.remainder[DIVISORLEN-1:0] = div_remainder;
        end
`else
        w_wr_entry.quotient[DIVIDENDLEN-1:0] = div_quotient;
        w_wr_entry.remainder[DIVISORLEN-1:0] = div_remainder;
        w_wr_entry.divzero                   = w_shadow_out.divzero;
`endif
    end

    div_result_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_wr_en   (w_shadow_out.valid),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_entry),
        .o_empty   (w_fifo_empty)
    );

    assign rsp_valid     = ~w_fifo_empty;
    assign w_pop         = rsp_valid & rsp_ready;
    assign rsp_id        = rsp_valid & w_rd_entry.id;
    assign rsp_quotient  = rsp_valid ? w_rd_entry.quotient[DIVIDENDLEN-1:0] : '0;
    assign rsp_remainder = rsp_valid ? w_rd_entry.remainder[DIVISORLEN-1:0] : '0;
`ifdef DIV_SCHED_DIVZERO_EN
    assign rsp_divzero   = rsp_valid & w_rd_entry.divzero;
`endif
    // Upper result bits are sized for the widest divider and stay zero here.
    assign w_unused_rd   = ^w_rd_entry;

    assign busy = (r_credits != CREDIT_MAX);

    // Credits count free buffer slots minus ops already in the divider, so a capture always has room.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_active  <= 1'b0;
            r_ptr     <= 1'b0;
            r_credits <= CREDIT_MAX;
        end else begin
            r_active <= 1'b1;
            if (w_issue) begin
                r_ptr <= ~w_grant_id;
            end
            case ({w_issue, w_pop})
                2'b10:   r_credits <= r_credits - CREDIT_ONE;
                2'b01:   r_credits <= r_credits + CREDIT_ONE;
                default: r_credits <= r_credits;
            endcase
        end
    end

endmodule
